// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential restoring divider.
//   DIV_WIDTH    default operand/result width
//   div_state_e  controller state encoding (IDLE, CALC, DONE)
//   DIV_CNT_W    iteration counter width for the default width
//   div_cnt_w()  iteration counter width for any width: clog2(w+1)
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // The counter must be able to hold the value w itself, because that
  // value marks the commit cycle.
  function automatic int div_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

endpackage

// File: rtl/ripple_borrow_subtractor.sv
// ripple_borrow_subtractor: combinational W-bit A-B built from a chain of
// full-subtractor cells (borrow ripples from LSB to MSB).
//   a, b        : input  logic [W-1:0]  minuend, subtrahend
//   diff        : output logic [W-1:0]  a - b (modulo 2^W)
//   borrow_out  : output logic          1 when a < b (unsigned)
// Also contains full_subtractor, the one-bit cell.

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module ripple_borrow_subtractor #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow_out
);
  logic [W:0] brw;

  assign brw[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_cell
    full_subtractor u_fs (
      .a   (a[i]),
      .b   (b[i]),
      .bin (brw[i]),
      .d   (diff[i]),
      .bout(brw[i+1])
    );
  end

  assign borrow_out = brw[W];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per
// clock (shift in next dividend bit, trial-subtract divisor, keep or restore).
//   Clk        : input  1      rising-edge clock
//   reset      : input  1      synchronous, active-low
//   start      : input  1      request; accepted only when not busy
//   dividend   : input  WIDTH  numerator, captured on accept
//   divisor    : input  WIDTH  denominator, captured on accept
//   quotient   : output WIDTH  registered result
//   remainder  : output WIDTH  registered result
//   busy       : output 1      division in progress
//   done       : output 1      quotient/remainder valid
//   div_zero   : output 1      captured divisor was zero (valid with done)
// Build option: define DIV_EARLY_ZERO_EN to finish a divide-by-zero one
// cycle after accept instead of running all WIDTH iterations.
// Timing: start accepted at edge k -> WIDTH iterations on edges k+1..k+WIDTH
// -> commit on edge k+WIDTH+1.

module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = div_cnt_w(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;          // partial remainder, one guard bit
  logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend shift register, MSB first
  logic [WIDTH-1:0] dvs_q, dvs_d;      // captured divisor
  logic [WIDTH-1:0] qsh_q, qsh_d;      // quotient bits as they are produced
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   sub_a, sub_b, sub_diff;
  logic             sub_borrow;

  assign sub_a = {r_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign sub_b = {1'b0, dvs_q};

  ripple_borrow_subtractor #(.W(WIDTH + 1)) u_sub (
    .a         (sub_a),
    .b         (sub_b),
    .diff      (sub_diff),
    .borrow_out(sub_borrow)
  );

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    qsh_d       = qsh_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = done_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dvd_d      = dividend;
          dvs_d      = divisor;
          r_d        = '0;
          qsh_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          div_zero_d = 1'b0;
          state_d    = CALC;
`ifdef DIV_EARLY_ZERO_EN
          // Preload the values the full iteration would converge to and
          // jump the counter to the commit cycle.
          if (divisor == '0) begin
            r_d   = {1'b0, dividend};
            qsh_d = '1;
            cnt_d = CW'(WIDTH);
          end
`endif
        end
      end

      CALC: begin
        if (cnt_q == CW'(WIDTH)) begin
          quotient_d  = qsh_q;
          remainder_d = r_q[WIDTH-1:0];
          div_zero_d  = (dvs_q == '0);
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
        end else begin
          // Borrow means the trial difference went negative: restore.
          r_d   = sub_borrow ? sub_a : sub_diff;
          qsh_d = {qsh_q[WIDTH-2:0], ~sub_borrow};
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      r_q         <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      qsh_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      qsh_q       <= qsh_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider (WIDTH=8).
// Build option DIV_EARLY_ZERO_EN changes the expected divide-by-zero latency.
module tb_seq_divider;

  localparam int W = 8;

`ifdef DIV_EARLY_ZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = W + 1;
`endif

  logic         Clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; returns right after the accept edge (+#1).
  task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done, checking that busy stays high and the visible
  // results stay frozen until the commit edge. Returns edges waited.
  task automatic wait_done(input string tag, input logic [W-1:0] prev_q,
                           input logic [W-1:0] prev_r, input int inject_at,
                           output int n);
    int bad;
    bad = 0;
    n   = 0;
    while (done !== 1'b1 && n < 20) begin
      if (n + 1 == inject_at) begin
        @(negedge Clk);
        dividend = 8'd50;
        divisor  = 8'd2;
        start    = 1'b1;
      end
      @(posedge Clk);
      #1;
      start = 1'b0;
      n++;
      if (done !== 1'b1 && (busy !== 1'b1 || quotient !== prev_q || remainder !== prev_r))
        bad++;
    end
    check({tag, "_hold"}, bad, 0);
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                         input int lat, input int inject_at);
    logic [W-1:0] pq, pr;
    int n;
    pq = quotient;
    pr = remainder;
    pulse_start(a, b);
    check({tag, "_accept_busy"}, busy, 1);
    check({tag, "_accept_done"}, done, 0);
    wait_done(tag, pq, pr, inject_at, n);
    check({tag, "_latency"}, n, lat);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, div_zero, ez);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    @(negedge Clk);
    reset = 1'b1;

    run_div("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, 0);
    run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, 0);
    run_div("d5_9",   8'd5,   8'd9, 8'd0,   8'd5, 1'b0, 9, 0);
    run_div("d9_9",   8'd9,   8'd9, 8'd1,   8'd0, 1'b0, 9, 0);
    run_div("d77_0",  8'd77,  8'd0, 8'd255, 8'd77, 1'b1, ZLAT, 0);
    run_div("d0_5",   8'd0,   8'd5, 8'd0,   8'd0, 1'b0, 9, 0);
    // Second start at the 4th cycle after accept must be ignored.
    run_div("busy_ign", 8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 9, 4);

    // Reset during the 5th iteration wipes everything.
    pulse_start(8'd200, 8'd7);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    reset = 1'b0;
    @(posedge Clk);
    #1;
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_dz", div_zero, 0);
    @(negedge Clk);
    reset = 1'b1;
    // No spontaneous restart after reset release.
    repeat (3) @(posedge Clk);
    #1;
    check("postrst_idle_busy", busy, 0);

    run_div("d17_4", 8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 9, 0);
    // Started straight from DONE: done must drop on the accept edge.
    run_div("b2b_60_6", 8'd60, 8'd6, 8'd10, 8'd0, 1'b0, 9, 0);
    run_div("d254_16", 8'd254, 8'd16, 8'd15, 8'd14, 1'b0, 9, 0);

    // Results hold while sitting in DONE.
    repeat (5) @(posedge Clk);
    #1;
    check("hold_done", done, 1);
    check("hold_q", quotient, 15);
    check("hold_r", remainder, 14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
